axil_initiator: RTL
===================

# axil_initiator

Single-outstanding AXI4-Lite initiator. Converts a simple valid/ready command port (address, write flag, data, strobe) into AXI4-Lite read or write transactions and returns the response on a valid/ready response port. It is the manager-side counterpart of the register-slave peripherals on the peripheral link, such as system control. Typical users are a boot sequencer or a debug bridge programming SYS_CTRL boot address, hart ID and PLL registers before releasing core resets.

## Interface
- req_t: default logic; AXI4-Lite request struct, same typedef as the slaves use (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- resp_t: default logic; AXI4-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).
- TIMEOUT_CYCLES: default 1024; cycles a transaction may stay outstanding before timeout_o asserts; 0 disables the timeout.
- clk_i  in  1  system clock; one clock domain.
- arst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when both are high.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  byte address; ADDR_WIDTH = $bits(req_o.aw.addr).
- cmd_wdata_i  in  32  write data.
- cmd_wstrb_i  in  4  write byte strobes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when both are high.
- rsp_rdata_o  out  32  read data; 0 for writes.
- rsp_resp_o  out  2  AXI response code (bresp or rresp).
- req_o  out  req_t  AXI4-Lite request to the interconnect.
- resp_i  in  resp_t  AXI4-Lite response from the interconnect.
- busy_o  out  1  high in any state other than IDLE.
- timeout_o  out  1  current transaction has exceeded TIMEOUT_CYCLES.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE
  - cmd_ready_o = 1.
  - On handshake, register address, data and strobe.
  - Go to WR_REQ if cmd_write_i is 1, otherwise RD_REQ.
- WR_REQ
  - aw_valid and w_valid are driven independently from two flags, both set on entry.
  - Each flag clears on its own ready handshake. AW and W may complete in the same cycle or in either order.
  - When both flags are clear, go to WR_RESP.
- WR_RESP
  - b_ready = 1.
  - On b_valid, capture b.resp and set rdata to 0, then go to RSP.
- RD_REQ
  - ar_valid = 1 until ar_ready is seen, then go to RD_RESP.
- RD_RESP
  - r_ready = 1.
  - On r_valid, capture r.data and r.resp, then go to RSP.
- RSP
  - rsp_valid_o = 1 and the captured response is held stable.
  - On rsp_ready_i, go to IDLE.
- aw.prot and ar.prot = 3'b000.
- While AXI valid is not asserted, aw.addr, ar.addr, w.data and w.strb still reflect the registered command.
- A valid, once asserted, is never dropped before its ready. The AXI rules take priority over the timeout.
- Timeout counter
  - Cleared on command acceptance; increments in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - Saturates at TIMEOUT_CYCLES.
  - timeout_o = 1 while the counter equals TIMEOUT_CYCLES and the state is not IDLE or RSP.
  - The transaction is not aborted; it completes normally when the slave answers.
- Slave error responses (2'b10, 2'b11) pass through unchanged on rsp_resp_o. No retry is attempted.
- Reset values: all AXI valids 0; b_ready and r_ready 0; addresses, data and strobes 0; cmd_ready_o 1; rsp_valid_o 0; rsp_rdata_o 0; rsp_resp_o 0; busy_o 0; timeout_o 0; state IDLE; counter 0.
- Reset asserted mid-transaction returns the block to IDLE immediately. The interconnect and slave must share the same reset.

## Timing
- Cycle numbering: command accept = cycle 0.
- Request valids are registered:
  - Writes: aw_valid and w_valid first high in cycle 1.
  - Reads: ar_valid first high in cycle 1.
- Minimum latency with zero-wait slaves:
  - Write: ready in cycle 1, b_valid in cycle 2, rsp_valid_o in cycle 3.
  - Read: ar_ready in cycle 1, r_valid in cycle 2, rsp_valid_o in cycle 3.
- b_ready and r_ready are asserted only in their RESP states. A b_valid or r_valid arriving earlier is held by the slave.
- If rsp_ready_i is already high in cycle 3, cmd_ready_o is high again in cycle 4. Sustained throughput is one transaction per 4 cycles.
- cmd_ready_o is combinational from state only; it does not depend on cmd_valid_i.
- With TIMEOUT_CYCLES = N, timeout_o first rises N cycles after cycle 1 if the transaction is still outstanding.

## Structure
- Shared package hyper_titan_pkg:
  - axil_initiator_state_e enum.
  - Response code constants AXI_RESP_OKAY = 2'b00, AXI_RESP_EXOKAY = 2'b01, AXI_RESP_SLVERR = 2'b10, AXI_RESP_DECERR = 2'b11. The same constants are reused by the register slaves.
- Single module; no sub-module. The FSM, the two write-channel flags and the timeout counter all live in axil_initiator.

## Test plan
- Write 0x8000_0000 to SYS_CTRL BOOT_ADDR_E_CORE with strobe 0xF against a zero-wait slave -> rsp_valid_o in cycle 3, rsp_resp_o = 2'b00; a read-back returns 0x8000_0000 with 2'b00.
- Write where w_ready rises 2 cycles before aw_ready (then the reverse order) -> w_valid drops after its handshake, aw_valid holds, exactly one b_ready handshake, rsp_resp_o = 2'b00.
- Read from an unmapped offset -> rsp_resp_o = 2'b10, rsp_rdata_o = 0.
- rsp_ready_i held low 5 cycles -> rsp_valid_o and the data stay stable, cmd_ready_o stays 0, no AXI valid is asserted.
- TIMEOUT_CYCLES = 8 with a slave whose ar_ready stalls for 20 cycles -> timeout_o rises in cycle 9 and ar_valid stays high; the read then completes normally and timeout_o falls.
- arst_i pulsed while in WR_RESP -> all outputs at reset values in the same cycle, and a subsequent read completes with 2'b00.

Source files
------------

// File: rtl/hyper_titan_pkg.sv
// hyper_titan_pkg: types and constants shared by the peripheral-link
// managers and register slaves.
//   - AXI4-Lite channel payload structs and the request/response bundles
//   - AXI response code constants
//   - axil_initiator FSM state encoding
package hyper_titan_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
    logic [2:0]             prot;
  } axil_ax_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } axil_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axil_b_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [1:0]             resp;
  } axil_r_t;

  typedef struct packed {
    axil_ax_t aw;
    logic     aw_valid;
    axil_w_t  w;
    logic     w_valid;
    logic     b_ready;
    axil_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axil_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    axil_b_t b;
    logic    b_valid;
    logic    ar_ready;
    axil_r_t r;
    logic    r_valid;
  } axil_resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_initiator_state_e;

endpackage

// File: rtl/axil_initiator.sv
// axil_initiator: single-outstanding AXI4-Lite manager. Turns a valid/ready
// command (addr, write flag, data, strobe) into one AXI4-Lite read or write
// and returns the slave's answer on a valid/ready response port.
// Ports:
//   clk_i, arst_i                     clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o           command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_wstrb_i          command payload
//   rsp_valid_o/rsp_ready_i           response handshake
//   rsp_rdata_o, rsp_resp_o           read data (0 for writes), AXI resp code
//   req_o / resp_i                    AXI4-Lite bundle to/from interconnect
//   busy_o                            not IDLE
//   timeout_o                         outstanding for TIMEOUT_CYCLES or more
module axil_initiator
  import hyper_titan_pkg::*;
#(
  parameter type         req_t          = axil_req_t,
  parameter type         resp_t         = axil_resp_t,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_WIDTH     = AXIL_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  input  logic [3:0]            cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output req_t                  req_o,
  input  resp_t                 resp_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  // Counter only needs to reach TIMEOUT_CYCLES; with 0 it stays at 0 and
  // timeout_o is disabled below.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  axil_initiator_state_e state_q;
  logic                  aw_pend_q;
  logic                  w_pend_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           rdata_q;
  logic [1:0]            resp_q;
  logic [CNT_W-1:0]      cnt_q;

  logic outstanding;
  logic aw_done;
  logic w_done;

  assign outstanding = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_RESP);

  // A write channel is done once its flag is clear or its handshake lands now.
  assign aw_done = !aw_pend_q || resp_i.aw_ready;
  assign w_done  = !w_pend_q  || resp_i.w_ready;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (outstanding && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            wstrb_q <= cmd_wstrb_i;
            cnt_q   <= '0;
            if (cmd_write_i) begin
              aw_pend_q <= 1'b1;
              w_pend_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              state_q <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W retire independently, in either order or together.
          if (aw_pend_q && resp_i.aw_ready) aw_pend_q <= 1'b0;
          if (w_pend_q && resp_i.w_ready)   w_pend_q  <= 1'b0;
          if (aw_done && w_done)            state_q   <= WR_RESP;
        end
        WR_RESP: begin
          if (resp_i.b_valid) begin
            resp_q  <= resp_i.b.resp;
            rdata_q <= '0;
            state_q <= RSP;
          end
        end
        RD_REQ: begin
          if (resp_i.ar_ready) state_q <= RD_RESP;
        end
        RD_RESP: begin
          if (resp_i.r_valid) begin
            rdata_q <= resp_i.r.data;
            resp_q  <= resp_i.r.resp;
            state_q <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address/data fields always show the registered command, even with valid low.
  always_comb begin
    req_o          = '0;
    req_o.aw.addr  = addr_q;
    req_o.aw.prot  = 3'b000;
    req_o.aw_valid = aw_pend_q;
    req_o.w.data   = wdata_q;
    req_o.w.strb   = wstrb_q;
    req_o.w_valid  = w_pend_q;
    req_o.b_ready  = (state_q == WR_RESP);
    req_o.ar.addr  = addr_q;
    req_o.ar.prot  = 3'b000;
    req_o.ar_valid = (state_q == RD_REQ);
    req_o.r_ready  = (state_q == RD_RESP);
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = (TIMEOUT_CYCLES != 0) && outstanding && (cnt_q == CNT_MAX);

endmodule
